pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Fetch-stage controller directly upstream of the instruction memory. Drives the word-aligned program counter onto the memory's `address_in`.
- Tracks the PC of the instruction the registered memory presents one cycle later, and flags it valid.
- Handles sequential increment, stall, beq-style branch redirect, j-style jump redirect and halt. Flushes the one wrong-path word on every redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- MEM_WORDS, 1024, instruction memory depth in words; used only by the optional bounds check.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on rising clk edge only.
- stall  in  1  hold PC and fetch outputs (downstream not ready).
- halt  in  1  enter HALT; pulse or level.
- branch_taken  in  1  downstream resolved a taken branch this cycle.
- jump  in  1  downstream decoded a jump this cycle.
- redirect_pc4  in  32  PC+4 of the branching/jumping instruction.
- branch_imm  in  16  signed word offset of the branch.
- jump_index  in  26  jump target index.
- pc_addr  out  32  address to instruction memory `address_in`.
- if_pc  out  32  PC of the word currently on the memory output.
- if_pc_plus4  out  32  if_pc + 4.
- if_valid  out  1  memory output is a valid, non-flushed instruction.
- fetch_state  out  2  00 RESET_WAIT, 01 RUN, 10 STALL, 11 HALT.
- addr_error  out  1  sticky out-of-range flag; driven 0 when the feature is absent.

Behaviour:
- Reset (reset==0 at posedge), from any state including mid-redirect or mid-stall:
  - pc_addr = RESET_PC, if_pc = RESET_PC, if_pc_plus4 = RESET_PC + 4.
  - if_valid = 0, addr_error = 0, state = RESET_WAIT.
- Memory has 1-cycle registered read. Each non-held cycle: if_pc <= pc_addr and if_pc_plus4 <= pc_addr + 4, so if_pc always names the word on the memory output.
- Next-PC priority per cycle: jump > branch_taken > halt > stall > sequential.
- Sequential: pc_addr <= pc_addr + 4, modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
- Branch target: redirect_pc4 + (sign_extend32(branch_imm) << 2), modulo 2^32.
- Jump target: {redirect_pc4[31:28], jump_index, 2'b00}.
- pc_addr[1:0] is always 00.
- Redirect (jump or branch_taken) at cycle n:
  - pc_addr(n+1) = target.
  - if_valid(n+1) = 0, flushing the wrong-path word.
  - if_valid(n+2) = 1 with if_pc = target, unless stalled or halted.
  - Redirect overrides stall and halt in the same cycle; redirect wins.
  - Simultaneous jump and branch_taken: jump used.
- State machine:
  - RESET_WAIT: exactly 1 cycle, if_valid = 0. pc_addr advances to RESET_PC + 4 (or a redirect/halt/stall target), then RUN (or HALT/STALL per priority).
  - RUN: sequential/redirect; if_valid = 1 except the flush cycle.
  - STALL (stall==1, no redirect): pc_addr, if_pc, if_pc_plus4, if_valid all held. Memory re-reads the same address, so the instruction is stable. Return to RUN the cycle after stall drops.
  - HALT: pc_addr and if_pc held; if_valid = 0. Exit only by reset or redirect (redirect to RUN with the flush rule).
- stall asserted during RESET_WAIT: go to STALL with if_valid held at 0.

Optional Feature:
- Macro: PC_BOUNDS_CHECK_EN.
- Defined: when the next pc_addr >> 2 >= MEM_WORDS (sequential or redirect):
  - pc_addr still updates to that value.
  - addr_error sets on the same edge and stays sticky until reset.
  - State goes to HALT; if_valid = 0 from that edge on.
- Not defined: no check; addr_error tied to 0; addresses wrap modulo 2^32 only.

Test Plan:
- Reset release, no stall, 4 cycles: pc_addr 0,4,8,C,10; if_valid 0 in RESET_WAIT, then 1 with if_pc 0,4,8.
- Branch: branch_taken=1, redirect_pc4=0x10, branch_imm=-2: next pc_addr=0x08; following cycle if_valid=0; then if_valid=1, if_pc=0x08.
- Jump plus branch same cycle: jump_index=0x40, redirect_pc4=0x1000_0010 gives pc_addr=0x1000_0100 (jump wins); flush cycle observed.
- Stall held 3 cycles at pc_addr=0x0C: all outputs constant, fetch_state=10. Release gives pc_addr=0x10 next cycle.
- reset=0 asserted mid-stall and mid-redirect: next edge pc_addr=RESET_PC, if_valid=0, fetch_state=00. Also confirm a reset asserted only between clock edges has no effect.
- With PC_BOUNDS_CHECK_EN, MEM_WORDS=4, run sequentially: at pc_addr=0x10, addr_error=1 and HALT, sticky until reset. Without the macro: addr_error=0 and the PC continues.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC controller feeding a 1-cycle registered instruction memory.
// Optional out-of-range detection is built when PC_BOUNDS_CHECK_EN is defined.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic [31:0] redirect_pc4,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  output logic [31:0] pc_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic [1:0]  fetch_state,
  output logic        addr_error
);

  typedef enum logic [1:0] {
    S_RESET_WAIT = 2'b00,
    S_RUN        = 2'b01,
    S_STALL      = 2'b10,
    S_HALT       = 2'b11
  } state_t;

`ifdef PC_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_pc4;
  logic        r_valid;
  logic        r_err;

  logic [31:0] w_pc_seq;
  logic [31:0] w_br_sum;
  logic [31:0] w_br_target;
  logic [31:0] w_jmp_target;
  logic [31:0] w_redirect_pc;
  logic        w_redirect;
  logic        w_redirect_oor;
  logic        w_seq_oor;

  always_comb begin
    w_pc_seq      = r_pc + 32'd4;
    w_br_sum      = redirect_pc4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
    w_br_target   = {w_br_sum[31:2], 2'b00};
    w_jmp_target  = {redirect_pc4[31:28], jump_index, 2'b00};
    w_redirect    = jump | branch_taken;
    // Jump outranks a simultaneously taken branch.
    w_redirect_pc = jump ? w_jmp_target : w_br_target;
    w_redirect_oor = BOUNDS_EN && ({2'b00, w_redirect_pc[31:2]} >= MEM_WORDS);
    w_seq_oor      = BOUNDS_EN && ({2'b00, w_pc_seq[31:2]} >= MEM_WORDS);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_RESET_WAIT;
      r_pc     <= RESET_PC_ALIGNED;
      r_if_pc  <= RESET_PC_ALIGNED;
      r_if_pc4 <= RESET_PC_ALIGNED + 32'd4;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else if (BOUNDS_EN && r_err) begin
      // An address fault parks the unit until the next reset.
      r_state <= S_HALT;
      r_valid <= 1'b0;
    end else if (w_redirect) begin
      r_pc     <= w_redirect_pc;
      r_if_pc  <= r_pc;
      r_if_pc4 <= w_pc_seq;
      r_valid  <= 1'b0;
      if (w_redirect_oor) begin
        r_err   <= 1'b1;
        r_state <= S_HALT;
      end else begin
        r_state <= S_RUN;
      end
    end else if (halt || r_state == S_HALT) begin
      r_valid <= 1'b0;
      r_state <= S_HALT;
    end else if (stall) begin
      // Memory keeps re-reading the same address, so every output just holds.
      r_state <= S_STALL;
    end else begin
      r_pc     <= w_pc_seq;
      r_if_pc  <= r_pc;
      r_if_pc4 <= w_pc_seq;
      if (w_seq_oor) begin
        r_err   <= 1'b1;
        r_valid <= 1'b0;
        r_state <= S_HALT;
      end else begin
        r_valid <= 1'b1;
        r_state <= S_RUN;
      end
    end
  end

  assign pc_addr     = r_pc;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc4;
  assign if_valid    = r_valid;
  assign fetch_state = r_state;
  assign addr_error  = BOUNDS_EN ? r_err : 1'b0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table plus bounds/glitch sequences,
// expected results flow through a scoreboard queue.
module tb_pc_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, halt, branch_taken, jump;
  logic [31:0] redirect_pc4;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] pc_addr, if_pc, if_pc_plus4;
  logic        if_valid, addr_error;
  logic [1:0]  fetch_state;

  logic        b_reset;
  logic        b_zero1;
  logic [31:0] b_zero32;
  logic [15:0] b_zero16;
  logic [25:0] b_zero26;
  logic [31:0] b_pc_addr, b_if_pc, b_if_pc_plus4;
  logic        b_if_valid, b_addr_error;
  logic [1:0]  b_fetch_state;

  pc_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(32'h4000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .branch_taken(branch_taken), .jump(jump), .redirect_pc4(redirect_pc4),
    .branch_imm(branch_imm), .jump_index(jump_index), .pc_addr(pc_addr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_valid(if_valid),
    .fetch_state(fetch_state), .addr_error(addr_error)
  );

  pc_fetch_unit #(.RESET_PC(32'h0), .MEM_WORDS(4)) dut_small (
    .clk(clk), .reset(b_reset), .stall(b_zero1), .halt(b_zero1),
    .branch_taken(b_zero1), .jump(b_zero1), .redirect_pc4(b_zero32),
    .branch_imm(b_zero16), .jump_index(b_zero26), .pc_addr(b_pc_addr),
    .if_pc(b_if_pc), .if_pc_plus4(b_if_pc_plus4), .if_valid(b_if_valid),
    .fetch_state(b_fetch_state), .addr_error(b_addr_error)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic        v;
    logic [1:0]  st;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rst, stl, hlt, br, jp;
    logic [31:0] rpc4;
    logic [15:0] imm;
    logic [25:0] idx;
    exp_t        e;
  } vec_t;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t exp_q[$];
  vec_t vecs[$];

  function automatic exp_t mk_e(logic [31:0] pc, logic [31:0] ifpc, logic v,
                                logic [1:0] st, logic err);
    exp_t e;
    e.pc = pc; e.ifpc = ifpc; e.v = v; e.st = st; e.err = err;
    return e;
  endfunction

  function automatic vec_t mk(logic rst, logic stl, logic hlt, logic br, logic jp,
                              logic [31:0] rpc4, logic [15:0] imm, logic [25:0] idx,
                              logic [31:0] pc, logic [31:0] ifpc, logic v, logic [1:0] st);
    vec_t r;
    r.rst = rst; r.stl = stl; r.hlt = hlt; r.br = br; r.jp = jp;
    r.rpc4 = rpc4; r.imm = imm; r.idx = idx;
    r.e = mk_e(pc, ifpc, v, st, 1'b0);
    return r;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check(string tag, logic [31:0] pc, logic [31:0] ifpc, logic [31:0] ifpc4,
                       logic v, logic [1:0] st, logic err);
    exp_t e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = exp_q.pop_front();
    cmp({tag, ".pc_addr"},     pc,    e.pc);
    cmp({tag, ".if_pc"},       ifpc,  e.ifpc);
    cmp({tag, ".if_pc_plus4"}, ifpc4, e.ifpc + 32'd4);
    cmp({tag, ".if_valid"},    {31'd0, v},   {31'd0, e.v});
    cmp({tag, ".fetch_state"}, {30'd0, st},  {30'd0, e.st});
    cmp({tag, ".addr_error"},  {31'd0, err}, {31'd0, e.err});
    $display("txn %s: pc_addr=%h if_pc=%h if_valid=%0d state=%b addr_error=%0d",
             tag, pc, ifpc, v, st, err);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t bexp[$];
    logic brst[$];

    reset = 1'b0; stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    redirect_pc4 = '0; branch_imm = '0; jump_index = '0;
    b_reset = 1'b0; b_zero1 = 1'b0; b_zero32 = '0; b_zero16 = '0; b_zero26 = '0;

    //                rst stl hlt br jp  rpc4          imm       idx          pc            ifpc          v  st
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h4,        32'h0,        1, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h8,        32'h4,        1, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'hC,        32'h8,        1, 2'b01));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'hC,        32'h8,        1, 2'b10));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'hC,        32'h8,        1, 2'b10));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'hC,        32'h8,        1, 2'b10));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h10,       32'hC,        1, 2'b01));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h10,       16'hFFFE, 26'h0,       32'h8,        32'h10,       0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'hC,        32'h8,        1, 2'b01));
    vecs.push_back(mk(1, 0, 0, 1, 1, 32'h1000_0010, 16'h5,   26'h40,      32'h1000_0100, 32'hC,       0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h1000_0104, 32'h1000_0100, 1, 2'b01));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,        16'h0,    26'h0,       32'h1000_0104, 32'h1000_0100, 0, 2'b11));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h1000_0104, 32'h1000_0100, 0, 2'b11));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h1000_0104, 32'h1000_0100, 0, 2'b11));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h1000_0104, 16'h10,  26'h0,       32'h1000_0144, 32'h1000_0104, 0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h1000_0148, 32'h1000_0144, 1, 2'b01));
    vecs.push_back(mk(1, 1, 1, 1, 0, 32'h20,       16'h0,    26'h0,       32'h20,       32'h1000_0148, 0, 2'b01));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h20,       32'h1000_0148, 0, 2'b10));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h24,       32'h20,       1, 2'b01));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h24,       32'h20,       1, 2'b10));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        0, 2'b00));
    vecs.push_back(mk(1, 1, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'h0,        0, 2'b10));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h4,        32'h0,        1, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 1, 32'hF000_0000, 16'h0,   26'h3FF_FFFF, 32'hFFFF_FFFC, 32'h4,      0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'hFFFF_FFFC, 1, 2'b01));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h100,      16'h10,   26'h0,       32'h140,      32'h0,        0, 2'b01));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0,        16'h0,    26'h5,       32'h0,        32'h0,        0, 2'b00));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h4,        32'h0,        1, 2'b01));
    vecs.push_back(mk(1, 0, 0, 1, 0, 32'h4,        16'hFFFE, 26'h0,       32'hFFFF_FFFC, 32'h4,       0, 2'b01));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,        16'h0,    26'h0,       32'h0,        32'hFFFF_FFFC, 1, 2'b01));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst; stall = vecs[i].stl; halt = vecs[i].hlt;
      branch_taken = vecs[i].br; jump = vecs[i].jp;
      redirect_pc4 = vecs[i].rpc4; branch_imm = vecs[i].imm; jump_index = vecs[i].idx;
      exp_q.push_back(vecs[i].e);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), pc_addr, if_pc, if_pc_plus4, if_valid, fetch_state, addr_error);
    end

    // A reset pulse entirely between edges must be ignored.
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    exp_q.push_back(mk_e(32'h4, 32'h0, 1'b1, 2'b01, 1'b0));
    @(posedge clk);
    #1;
    check("glitch_reset", pc_addr, if_pc, if_pc_plus4, if_valid, fetch_state, addr_error);

    // Small-memory instance: sequential run across the 4-word boundary.
    brst = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bexp.push_back(mk_e(32'h0,  32'h0, 1'b0, 2'b00, 1'b0));
    bexp.push_back(mk_e(32'h4,  32'h0, 1'b1, 2'b01, 1'b0));
    bexp.push_back(mk_e(32'h8,  32'h4, 1'b1, 2'b01, 1'b0));
    bexp.push_back(mk_e(32'hC,  32'h8, 1'b1, 2'b01, 1'b0));
`ifdef PC_BOUNDS_CHECK_EN
    bexp.push_back(mk_e(32'h10, 32'hC, 1'b0, 2'b11, 1'b1));
    bexp.push_back(mk_e(32'h10, 32'hC, 1'b0, 2'b11, 1'b1));
    bexp.push_back(mk_e(32'h10, 32'hC, 1'b0, 2'b11, 1'b1));
`else
    bexp.push_back(mk_e(32'h10, 32'hC,  1'b1, 2'b01, 1'b0));
    bexp.push_back(mk_e(32'h14, 32'h10, 1'b1, 2'b01, 1'b0));
    bexp.push_back(mk_e(32'h18, 32'h14, 1'b1, 2'b01, 1'b0));
`endif
    bexp.push_back(mk_e(32'h0,  32'h0, 1'b0, 2'b00, 1'b0));

    foreach (brst[i]) begin
      @(negedge clk);
      b_reset = brst[i];
      exp_q.push_back(bexp[i]);
      @(posedge clk);
      #1;
      check($sformatf("bounds%0d", i), b_pc_addr, b_if_pc, b_if_pc_plus4,
            b_if_valid, b_fetch_state, b_addr_error);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
